vector_result_serializer: RTL and testbench
===========================================

// Module: vector_result_serializer
// PURPOSE
// - Consumer end of the vector ALU result bus: captures one 256-bit result (16 lanes x 16 b) plus its 64-bit lane flags.
// - Replays the captured result as lane-masked write beats on a narrow valid/ready write port (vector store / writeback path).
// - Optionally reduces the per-lane flags to one 4-bit summary.
// PARAMETERS
// - LANE_W      16  lane width in bits; LANES*LANE_W must equal 256
// - LANES       16  lanes per vector
// - BEAT_LANES  1   lanes per write beat; legal values 1,2,4,8,16 (must divide LANES)
// - ADDR_W      32  byte-address width
// PORTS
// - clk           in   1                  clock; all state on rising edge
// - rst           in   1                  asynchronous reset, active-low (0 = reset)
// - in_valid      in   1                  result/flags/lane_mask/base_addr valid
// - in_ready      out  1                  serializer can accept a new vector
// - result        in   256                ALU result; lane i = result[16i+15:16i]
// - flags         in   64                 ALU flags; lane i = flags[4i+3:4i] = {N,Z,C,V}
// - lane_mask     in   LANES              1 = lane is written
// - base_addr     in   ADDR_W             byte address of lane 0
// - wr_valid      out  1                  write beat valid
// - wr_ready      in   1                  sink accepts beat
// - wr_addr       out  ADDR_W             base_addr + beat_idx*BEAT_LANES*LANE_W/8
// - wr_data       out  BEAT_LANES*LANE_W  lanes of current beat, lowest lane in LSBs
// - wr_strb       out  BEAT_LANES         lane_mask bits of current beat
// - wr_last       out  1                  current beat is last non-skipped beat
// - done          out  1                  one-cycle pulse after final beat accepted (or empty mask)
// - flag_summary  out  4                  reduced flags {N,Z,C,V}, valid from capture until next capture
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE; in_ready=1 on release; wr_valid, wr_last, done=0; wr_addr, wr_data, wr_strb, flag_summary=0.
// - States: IDLE, SEND, DONE.
// - IDLE
//   - in_ready=1.
//   - in_valid&&in_ready at edge k captures all inputs into registers.
//   - If any lane_mask bit set: go SEND; first beat has wr_valid=1 in cycle k+1.
//   - If lane_mask==0: go DONE (no beats issued).
// - SEND
//   - in_ready=0.
//   - A beat is skipped when all of its wr_strb bits are 0; skipped beats never appear on the port but wr_addr still reflects the true beat index.
//   - wr_valid stays high, and wr_addr/data/strb/last are held stable, until wr_ready.
//   - On wr_valid&&wr_ready: if wr_last, go DONE and drop wr_valid next cycle; else advance to next non-skipped beat with no bubble (back-to-back beats when wr_ready stays 1).
// - DONE
//   - done=1 for exactly one cycle; in_ready=0.
//   - Next state is IDLE.
//   - Minimum capture-to-capture spacing = beats+2 cycles.
// - Inputs changing outside the capture edge have no effect; in_valid during SEND/DONE is ignored (upstream holds it).
// - Address arithmetic is modulo 2^ADDR_W; wrap-around is silent.
// - rst asserted mid-SEND abandons the vector immediately: wr_valid=0 asynchronously, no done pulse.
// CONFIGURATION
// - Macro VEC_FLAG_REDUCE_EN.
//   - Defined: flag_summary is registered at capture, computed over masked-in lanes only:
//     - N = OR of N
//     - Z = AND of Z
//     - C = OR of C
//     - V = OR of V
//   - Defined, empty mask: flag_summary = 4'b0100.
//   - Undefined: flag_summary tied to 4'b0000; no reduction logic synthesized.
// STRUCTURE
// - Package vector_pkg:
//   - VEC_W=256, LANES, LANE_W
//   - flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
//   - state enum {IDLE, SEND, DONE}
// - Sub-module vector_beat_picker (combinational priority encoder):
//   - Inputs: beat-level mask and current index.
//   - Outputs: next non-skipped beat index and is_last.
// TESTING
// - Full mask, BEAT_LANES=1, wr_ready=1, result lane i = 16'h1000+i, base 0x100:
//   - 16 consecutive beats, addr 0x100..0x11E step 2.
//   - wr_last on beat 15 only; done in the cycle after beat 15.
// - lane_mask=16'h8001:
//   - Exactly 2 beats: data 16'h1000 @0x100, then 16'h100F @0x11E with wr_last.
// - lane_mask=0:
//   - No wr_valid.
//   - done one cycle after capture; in_ready back 2 cycles after capture.
// - wr_ready held low 5 cycles on beat 3:
//   - wr_valid/addr/data stable throughout.
//   - Then continues; total 16 beats, no duplicates.
// - rst driven low during beat 7:
//   - wr_valid=0 immediately; no done pulse.
//   - in_ready=1 after release; next vector serializes from beat 0.
// - VEC_FLAG_REDUCE_EN, mask 16'h0003, flags lane0=4'b1100, lane1=4'b0101:
//   - flag_summary=4'b1101.
//   - Macro undefined: flag_summary=4'b0000.

Source files
------------

// File: rtl/vector_pkg.sv
// ---------------------------------------------------------------------------
// vector_pkg
// Shared definitions for the vector result serializer:
//   VEC_W / LANES / LANE_W  - geometry of one ALU result vector
//   FLAG_N/Z/C/V            - bit positions of the per-lane {N,Z,C,V} flags
//   state_t                 - serializer FSM states
// ---------------------------------------------------------------------------
package vector_pkg;

  localparam int VEC_W  = 256;
  localparam int LANES  = 16;
  localparam int LANE_W = 16;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/vector_beat_picker.sv
// ---------------------------------------------------------------------------
// vector_beat_picker
// Combinational priority encoder over a beat-level mask. Finds the lowest
// set beat at or above start_idx and reports whether any further set beat
// follows it.
// Ports:
//   beat_mask  in   BEATS     1 = beat carries at least one written lane
//   start_idx  in   IDX_W+1   first beat index to consider (extra bit lets
//                             "one past the last beat" be expressed)
//   next_idx   out  IDX_W     lowest set beat >= start_idx (0 if none)
//   found      out  1         a set beat exists at or above start_idx
//   is_last    out  1         no set beat exists above next_idx
// ---------------------------------------------------------------------------
module vector_beat_picker #(
  parameter int BEATS = 16,
  parameter int IDX_W = 4
) (
  input  logic [BEATS-1:0] beat_mask,
  input  logic [IDX_W:0]   start_idx,
  output logic [IDX_W-1:0] next_idx,
  output logic             found,
  output logic             is_last
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves a
    // value unassigned; otherwise synthesis would infer a latch.
    next_idx = '0;
    found    = 1'b0;
    is_last  = 1'b1;
    for (int b = 0; b < BEATS; b++) begin
      if (beat_mask[b] && (b >= int'(start_idx))) begin
        if (!found) begin
          next_idx = IDX_W'(b);
          found    = 1'b1;
        end else begin
          is_last = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/vector_result_serializer.sv
// ---------------------------------------------------------------------------
// vector_result_serializer
// Captures one vector ALU result (LANES x LANE_W) with its per-lane flags and
// replays it as lane-masked write beats on a valid/ready write port. Beats
// whose lanes are all masked off are skipped without a bubble; wr_addr always
// reflects the true beat index.
//
// Optional feature (macro VEC_FLAG_REDUCE_EN): flag_summary holds the {N,Z,C,V}
// reduction over masked-in lanes (N/C/V = OR, Z = AND), registered at capture.
// Without the macro flag_summary is tied to 0.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   in_valid/ready  capture handshake for result/flags/lane_mask/base_addr
//   result          LANES*LANE_W-bit result, lane i at [LANE_W*i +: LANE_W]
//   flags           4 bits per lane {N,Z,C,V}
//   lane_mask       1 = lane is written
//   base_addr       byte address of lane 0
//   wr_valid/ready  write beat handshake
//   wr_addr         base_addr + beat_idx * bytes per beat (modulo 2^ADDR_W)
//   wr_data         lanes of current beat, lowest lane in LSBs
//   wr_strb         lane_mask bits of current beat
//   wr_last         current beat is the last non-skipped beat
//   done            one-cycle pulse after the final beat (or empty mask)
//   flag_summary    reduced flags, valid from capture until next capture
// ---------------------------------------------------------------------------
module vector_result_serializer #(
  parameter int LANE_W     = vector_pkg::LANE_W,
  parameter int LANES      = vector_pkg::LANES,
  parameter int BEAT_LANES = 1,
  parameter int ADDR_W     = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [vector_pkg::VEC_W-1:0] result,
  input  logic [4*LANES-1:0]           flags,
  input  logic [LANES-1:0]             lane_mask,
  input  logic [ADDR_W-1:0]            base_addr,
  output logic                         wr_valid,
  input  logic                         wr_ready,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic [BEAT_LANES*LANE_W-1:0] wr_data,
  output logic [BEAT_LANES-1:0]        wr_strb,
  output logic                         wr_last,
  output logic                         done,
  output logic [3:0]                   flag_summary
);

  import vector_pkg::*;

  localparam int BEATS      = LANES / BEAT_LANES;
  localparam int BEAT_W     = BEAT_LANES * LANE_W;
  localparam int BEAT_BYTES = BEAT_W / 8;
  localparam int IDX_W      = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_t state, state_n;

  logic [VEC_W-1:0]  data_q;
  logic [LANES-1:0]  mask_q;
  logic [ADDR_W-1:0] base_q;
  logic [IDX_W-1:0]  beat_idx;
  logic              last_q;

  logic [BEATS-1:0]  in_beat_mask, q_beat_mask, pick_mask;
  logic [IDX_W:0]    pick_start;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_found, pick_last;
  logic              capture, accept;

  assign capture = in_valid && (state == IDLE);
  assign accept  = wr_ready && (state == SEND);

  // A beat is live when any of its lanes is masked in.
  always_comb begin
    in_beat_mask = '0;
    q_beat_mask  = '0;
    for (int b = 0; b < BEATS; b++) begin
      in_beat_mask[b] = |lane_mask[b*BEAT_LANES +: BEAT_LANES];
      q_beat_mask[b]  = |mask_q[b*BEAT_LANES +: BEAT_LANES];
    end
  end

  // One picker serves both lookups: in IDLE it finds the first beat of the
  // incoming vector, in SEND it finds the beat after the current one.
  assign pick_mask  = (state == IDLE) ? in_beat_mask : q_beat_mask;
  assign pick_start = (state == IDLE) ? '0 : ({1'b0, beat_idx} + (IDX_W+1)'(1));

  vector_beat_picker #(
    .BEATS (BEATS),
    .IDX_W (IDX_W)
  ) u_picker (
    .beat_mask (pick_mask),
    .start_idx (pick_start),
    .next_idx  (pick_idx),
    .found     (pick_found),
    .is_last   (pick_last)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = pick_found ? SEND : DONE;
      SEND:    if (wr_ready && last_q) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (!rst) begin
      state    <= IDLE;
      // NOTE: the wide capture registers are reset because wr_data/wr_strb/
      // wr_addr are required to read 0 during reset; they are not a RAM.
      data_q   <= '0;
      mask_q   <= '0;
      base_q   <= '0;
      beat_idx <= '0;
      last_q   <= 1'b0;
    end else begin
      state <= state_n;
      if (capture) begin
        data_q   <= result;
        mask_q   <= lane_mask;
        base_q   <= base_addr;
        beat_idx <= pick_idx;
        last_q   <= pick_last;
      end else if (accept && !last_q) begin
        beat_idx <= pick_idx;
        last_q   <= pick_last;
      end
    end
  end

  assign in_ready = (state == IDLE);
  assign wr_valid = (state == SEND);
  assign wr_last  = wr_valid && last_q;
  assign done     = (state == DONE);
  assign wr_data  = data_q[beat_idx*BEAT_W +: BEAT_W];
  assign wr_strb  = mask_q[beat_idx*BEAT_LANES +: BEAT_LANES];
  // Address wraps silently at 2^ADDR_W.
  assign wr_addr  = base_q + ADDR_W'(beat_idx) * ADDR_W'(BEAT_BYTES);

`ifdef VEC_FLAG_REDUCE_EN
  logic [3:0] flag_reduced, flag_q;

  // Seeded with the reduction identities (OR -> 0, AND -> 1), so an empty
  // mask yields 4'b0100.
  always_comb begin
    flag_reduced = 4'b0100;
    for (int i = 0; i < LANES; i++) begin
      if (lane_mask[i]) begin
        flag_reduced[FLAG_N] = flag_reduced[FLAG_N] | flags[4*i + FLAG_N];
        flag_reduced[FLAG_Z] = flag_reduced[FLAG_Z] & flags[4*i + FLAG_Z];
        flag_reduced[FLAG_C] = flag_reduced[FLAG_C] | flags[4*i + FLAG_C];
        flag_reduced[FLAG_V] = flag_reduced[FLAG_V] | flags[4*i + FLAG_V];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flag_q <= '0;
    end else if (capture) begin
      flag_q <= flag_reduced;
    end
  end

  assign flag_summary = flag_q;
`else
  logic unused_flags;
  assign unused_flags = ^flags;
  assign flag_summary = 4'b0000;
`endif

endmodule

// File: tb/tb_vector_result_serializer.sv
// ---------------------------------------------------------------------------
// tb_vector_result_serializer
// Randomized bench for vector_result_serializer. Expected beats come from a
// list model: every beat with a non-zero lane mask becomes one queue entry,
// the final entry carries last. Flag summary is modelled from the reduction
// rules. Directed cases cover full/sparse/empty masks, a stall, and reset
// during a transfer; random vectors follow.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vector_result_serializer;

  localparam int LANE_W     = 16;
  localparam int LANES      = 16;
  localparam int BL         = 1;
  localparam int ADDR_W     = 32;
  localparam int BEATS      = LANES / BL;
  localparam int BW         = BL * LANE_W;
  localparam int BEAT_BYTES = BW / 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [255:0]      result;
  logic [63:0]       flags;
  logic [LANES-1:0]  lane_mask;
  logic [ADDR_W-1:0] base_addr;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [BW-1:0]     wr_data;
  logic [BL-1:0]     wr_strb;
  logic              wr_last;
  logic              done;
  logic [3:0]        flag_summary;

  vector_result_serializer #(
    .LANE_W     (LANE_W),
    .LANES      (LANES),
    .BEAT_LANES (BL),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .result       (result),
    .flags        (flags),
    .lane_mask    (lane_mask),
    .base_addr    (base_addr),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_strb      (wr_strb),
    .wr_last      (wr_last),
    .done         (done),
    .flag_summary (flag_summary)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [BW-1:0]     data;
    logic [BL-1:0]     strb;
    logic              last;
  } beat_t;

  beat_t exp_q[$];

  function automatic void build_model(input logic [255:0] res, input logic [LANES-1:0] msk,
                                      input logic [ADDR_W-1:0] base);
    exp_q.delete();
    for (int b = 0; b < BEATS; b++) begin
      beat_t bt;
      bt.strb = msk[b*BL +: BL];
      if (bt.strb != '0) begin
        bt.addr = base + ADDR_W'(b * BEAT_BYTES);
        bt.data = res[b*BW +: BW];
        bt.last = 1'b0;
        exp_q.push_back(bt);
      end
    end
    if (exp_q.size() > 0) exp_q[exp_q.size()-1].last = 1'b1;
  endfunction

  function automatic logic [3:0] exp_flags(input logic [63:0] f, input logic [LANES-1:0] m);
`ifdef VEC_FLAG_REDUCE_EN
    logic n = 1'b0, z = 1'b1, c = 1'b0, v = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (m[i]) begin
        n = n | f[4*i+3];
        z = z & f[4*i+2];
        c = c | f[4*i+1];
        v = v | f[4*i+0];
      end
    end
    return {n, z, c, v};
`else
    return 4'b0000;
`endif
  endfunction

  task automatic scramble_inputs();
    in_valid  = 1'($urandom_range(0, 1));
    result    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    flags     = {$urandom, $urandom};
    lane_mask = LANES'($urandom);
    base_addr = $urandom;
  endtask

  // Drives one vector, then checks every cycle until the expected beat list
  // is drained, followed by the done pulse and the return to idle.
  task automatic run_vector(input string name, input logic [255:0] res, input logic [63:0] flg,
                            input logic [LANES-1:0] msk, input logic [ADDR_W-1:0] base,
                            input int stall_beat, input int stall_len, input bit rand_ready);
    int acc = 0;
    int stall_cnt = 0;
    int cycles = 0;
    logic [3:0] fexp;
    build_model(res, msk, base);
    fexp = exp_flags(flg, msk);
    @(negedge clk);
    check($sformatf("%s.in_ready_idle", name), in_ready, 1);
    in_valid  = 1'b1;
    result    = res;
    flags     = flg;
    lane_mask = msk;
    base_addr = base;
    @(negedge clk);
    scramble_inputs();
    check($sformatf("%s.flag_summary", name), flag_summary, fexp);
    while (acc < exp_q.size()) begin
      if (cycles > 300) begin
        check($sformatf("%s.beat_timeout", name), acc, exp_q.size());
        break;
      end
      cycles++;
      check($sformatf("%s.wr_valid[%0d]", name, acc), wr_valid, 1);
      check($sformatf("%s.wr_addr[%0d]", name, acc), wr_addr, exp_q[acc].addr);
      check($sformatf("%s.wr_data[%0d]", name, acc), wr_data, exp_q[acc].data);
      check($sformatf("%s.wr_strb[%0d]", name, acc), wr_strb, exp_q[acc].strb);
      check($sformatf("%s.wr_last[%0d]", name, acc), wr_last, exp_q[acc].last);
      check($sformatf("%s.done_early", name), done, 0);
      check($sformatf("%s.in_ready_busy", name), in_ready, 0);
      if (acc == stall_beat && stall_cnt < stall_len) begin
        wr_ready = 1'b0;
        stall_cnt++;
      end else begin
        wr_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (wr_ready) acc++;
      @(negedge clk);
      scramble_inputs();
    end
    in_valid = 1'b0;
    wr_ready = 1'($urandom_range(0, 1));
    check($sformatf("%s.done_pulse", name), done, 1);
    check($sformatf("%s.wr_valid_after", name), wr_valid, 0);
    check($sformatf("%s.in_ready_done", name), in_ready, 0);
    check($sformatf("%s.flag_hold_done", name), flag_summary, fexp);
    @(negedge clk);
    check($sformatf("%s.done_single", name), done, 0);
    check($sformatf("%s.in_ready_back", name), in_ready, 1);
    check($sformatf("%s.wr_valid_idle", name), wr_valid, 0);
    check($sformatf("%s.flag_hold_idle", name), flag_summary, fexp);
  endtask

  task automatic reset_mid_vector(input logic [255:0] res);
    build_model(res, '1, 32'h100);
    @(negedge clk);
    in_valid  = 1'b1;
    result    = res;
    flags     = '0;
    lane_mask = '1;
    base_addr = 32'h100;
    wr_ready  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("rst.beat7_valid", wr_valid, 1);
    check("rst.beat7_addr", wr_addr, exp_q[7].addr);
    check("rst.beat7_data", wr_data, exp_q[7].data);
    rst = 1'b0;
    #1;
    check("rst.wr_valid_async", wr_valid, 0);
    check("rst.wr_last", wr_last, 0);
    check("rst.done", done, 0);
    check("rst.wr_addr", wr_addr, 0);
    check("rst.wr_data", wr_data, 0);
    check("rst.wr_strb", wr_strb, 0);
    check("rst.flag_summary", flag_summary, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("rst.no_done", done, 0);
      check("rst.no_valid", wr_valid, 0);
      check("rst.in_ready_release", in_ready, 1);
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [255:0] ramp;
    logic [255:0] res;
    logic [63:0]  flg;
    logic [LANES-1:0] msk;
    logic [ADDR_W-1:0] base;

    rst       = 1'b1;
    in_valid  = 1'b0;
    wr_ready  = 1'b0;
    result    = '0;
    flags     = '0;
    lane_mask = '0;
    base_addr = '0;
    #3 rst = 1'b0;
    #1;
    check("reset.wr_valid", wr_valid, 0);
    check("reset.wr_last", wr_last, 0);
    check("reset.done", done, 0);
    check("reset.wr_addr", wr_addr, 0);
    check("reset.wr_data", wr_data, 0);
    check("reset.wr_strb", wr_strb, 0);
    check("reset.flag_summary", flag_summary, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset.in_ready_release", in_ready, 1);

    for (int i = 0; i < LANES; i++) ramp[16*i +: 16] = 16'h1000 + 16'(i);

    run_vector("full", ramp, 64'h0, 16'hFFFF, 32'h100, -1, 0, 1'b0);
    run_vector("ends", ramp, 64'h0, 16'h8001, 32'h100, -1, 0, 1'b0);
    run_vector("empty", ramp, {$urandom, $urandom}, 16'h0000, 32'h100, -1, 0, 1'b0);
    run_vector("stall", ramp, 64'h0, 16'hFFFF, 32'h100, 3, 5, 1'b0);

    reset_mid_vector(ramp);
    run_vector("after_rst", ramp, 64'h0, 16'hFFFF, 32'h100, -1, 0, 1'b0);

    flg = {$urandom, $urandom};
    flg[7:0] = 8'h5C;
    run_vector("flags", ramp, flg, 16'h0003, 32'h200, -1, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      res  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      flg  = {$urandom, $urandom};
      base = (n % 4 == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
      case ($urandom_range(0, 3))
        0:       msk = LANES'($urandom);
        1:       msk = LANES'($urandom & $urandom & $urandom);
        2:       msk = LANES'(1) << $urandom_range(0, LANES-1);
        default: msk = ($urandom_range(0, 3) == 0) ? '0 : '1;
      endcase
      run_vector($sformatf("rand%0d", n), res, flg, msk, base,
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 4)), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
